spart_host_ctrl: RTL and testbench
==================================

SPART_HOST_CTRL -- requirements
Module: spart_host_ctrl

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 13'd162, the baud divisor written to the SPART after reset.
REQ-002 SHALL have ports: clk input 1, system clock; rst input 1, reset (one clock; reset is synchronous and active-high).
REQ-003 SHALL have ports: iocs_n output 1, SPART chip select (active low); iorw_n output 1, 1=read/0=write; ioaddr output 2, 00=DBUF 01=SREG 10=DBL 11=DBH; databus inout 8, SPART data bus.
REQ-004 SHALL have ports: tx_q_full input 1, SPART TX queue full; rx_q_empty input 1, SPART RX queue empty.
REQ-005 SHALL have host ports: tx_valid input 1, tx_data input 8, tx_ready output 1; rx_valid output 1, rx_data output 8, rx_ready input 1; cfg_done output 1, baud configuration complete.

Function
REQ-006 Each SPART access SHALL occupy exactly one clk cycle with iocs_n=0; the bus is idle (iocs_n=1, iorw_n=1, ioaddr=00) in every other cycle.
REQ-007 databus SHALL be driven only when iocs_n=0 and iorw_n=0; it SHALL be high-Z otherwise.
REQ-008 Read data SHALL be captured at the clk edge ending the access cycle.
REQ-009 SREG format SHALL be [7:4] TX free entries (0..8) and [3:0] RX occupied entries (0..8).
REQ-010 FSM states SHALL be CFG_L, CFG_H, IDLE, POLL, SERVE, TX_WR, RX_RD; bus outputs SHALL be decoded from state only, except databus write data.
REQ-011 CFG_L: write DBL = BAUD_DIV[7:0]; go to CFG_H.
REQ-012 CFG_H: write DBH = {3'b000, BAUD_DIV[12:8]}; go to IDLE; cfg_done SHALL be 1 from the first IDLE cycle until the next reset.
REQ-013 IDLE: go to POLL when (tx_valid and !tx_q_full) or (!rx_q_empty and !rx_valid); otherwise stay in IDLE, bus idle.
REQ-014 POLL: read SREG; load tx_credit=SREG[7:4] and rx_credit=SREG[3:0] (4-bit counters); go to SERVE.
REQ-015 SERVE: bus-idle decision cycle; TX is eligible when tx_valid=1 and tx_credit!=0; RX is eligible when rx_credit!=0 and rx_valid=0.
REQ-016 SERVE with both eligible SHALL pick the class not served last (round-robin); the pointer SHALL favour TX after reset.
REQ-017 SERVE with only one eligible SHALL pick it; with none eligible SHALL clear both credits and go to IDLE.
REQ-018 TX_WR: write DBUF = tx_data; assert tx_ready for this cycle only; decrement tx_credit; go to SERVE.
REQ-019 tx_ready SHALL be 0 in every state except TX_WR; the host holds tx_data stable while tx_valid=1 and tx_ready=0.
REQ-020 RX_RD: read DBUF; load rx_data; set rx_valid=1 on the next cycle; decrement rx_credit; go to SERVE.
REQ-021 rx_valid and rx_data SHALL hold until a cycle with rx_valid=1 and rx_ready=1, after which rx_valid=0 on the next cycle.
REQ-022 Credits SHALL never decrement below 0 or wrap; SREG fields above 8 SHALL be loaded unmodified.
REQ-023 tx_q_full and rx_q_empty SHALL affect only the IDLE exit decision; in SERVE, credits alone gate accesses.

Reset
REQ-024 When rst=1 at a clk edge, the next state SHALL be CFG_L from any state, including mid-access.
REQ-025 Reset SHALL also set: credits=0, rr pointer=TX, rx_valid=0, rx_data=0, cfg_done=0, tx_ready=0, bus idle, databus high-Z.
REQ-026 While rst is held high, the bus SHALL remain idle; the CFG_L write SHALL occur in the first cycle after rst is deasserted.

Verification
REQ-027 Release rst -> cycle 1: iocs_n=0, iorw_n=0, ioaddr=10, databus=0xA2; cycle 2: ioaddr=11, databus=0x00; cycle 3: cfg_done=1, bus idle.
REQ-028 tx_valid=1, tx_data=0x5A, tx_q_full=0, SREG returns 0x80 -> POLL read of ioaddr=01, idle SERVE cycle, then a DBUF write of 0x5A with tx_ready=1 for exactly that cycle.
REQ-029 rx_q_empty=0, SREG=0x03, rx_ready=1 -> three DBUF reads, each followed by rx_valid=1 with the matching byte, then return to IDLE.
REQ-030 rx_ready=0 with SREG=0x03 -> one DBUF read, rx_valid held, no further reads or polls until rx_ready=1.
REQ-031 tx_valid held 1, SREG=0x22, rx_ready=1 -> access order TX, RX, TX, RX, then IDLE; SREG=0x10 with 3 TX bytes -> one write, then IDLE and a re-poll.
REQ-032 rst=1 during a TX_WR cycle -> next cycle iocs_n=1, databus high-Z, tx_ready=0, cfg_done=0; the CFG_L write follows after rst is deasserted.

Source files
------------

// File: rtl/spart_host_ctrl.sv
// Host-side controller for a SPART: writes the baud divisor after reset, then moves
// bytes between a valid/ready host interface and the SPART queues using SREG credits.
module spart_host_ctrl #(
    parameter logic [12:0] BAUD_DIV = 13'd162
) (
    input  logic       clk,
    input  logic       rst,
    output logic       iocs_n,
    output logic       iorw_n,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    input  logic       tx_q_full,
    input  logic       rx_q_empty,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       cfg_done
);

    localparam int unsigned CW = 4;
    localparam logic [1:0] ADDR_DBUF = 2'b00;
    localparam logic [1:0] ADDR_SREG = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    typedef enum logic [2:0] {
        CFG_L, CFG_H, IDLE, POLL, SERVE, TX_WR, RX_RD
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   tx_credit, rx_credit;
    logic            rr_tx;
    logic            tx_elig, rx_elig, pick_tx, pick_rx;
    logic            bus_drive;
    logic [7:0]      wdata;

    // Arbitration in SERVE: credits gate accesses, rr_tx breaks ties toward TX after reset
    assign tx_elig = tx_valid && (tx_credit != CW'(0));
    assign rx_elig = (rx_credit != CW'(0)) && !rx_valid;
    assign pick_tx = tx_elig && (!rx_elig || rr_tx);
    assign pick_rx = rx_elig && !pick_tx;

    always_ff @(posedge clk) begin
        if (rst) state <= CFG_L;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CFG_L: state_nxt = CFG_H;
            CFG_H: state_nxt = IDLE;
            IDLE: begin
                if ((tx_valid && !tx_q_full) || (!rx_q_empty && !rx_valid))
                    state_nxt = POLL;
            end
            POLL: state_nxt = SERVE;
            SERVE: begin
                if (pick_tx)      state_nxt = TX_WR;
                else if (pick_rx) state_nxt = RX_RD;
                else              state_nxt = IDLE;
            end
            TX_WR: state_nxt = SERVE;
            RX_RD: state_nxt = SERVE;
            default: state_nxt = CFG_L;
        endcase
    end

    // Bus strobes follow the state; held idle for the whole time rst is high
    always_comb begin
        iocs_n    = 1'b1;
        iorw_n    = 1'b1;
        ioaddr    = ADDR_DBUF;
        bus_drive = 1'b0;
        wdata     = 8'h00;
        tx_ready  = 1'b0;
        if (!rst) begin
            case (state)
                CFG_L: begin
                    iocs_n    = 1'b0;
                    iorw_n    = 1'b0;
                    ioaddr    = ADDR_DBL;
                    bus_drive = 1'b1;
                    wdata     = BAUD_DIV[7:0];
                end
                CFG_H: begin
                    iocs_n    = 1'b0;
                    iorw_n    = 1'b0;
                    ioaddr    = ADDR_DBH;
                    bus_drive = 1'b1;
                    wdata     = {3'b000, BAUD_DIV[12:8]};
                end
                POLL: begin
                    iocs_n = 1'b0;
                    ioaddr = ADDR_SREG;
                end
                TX_WR: begin
                    iocs_n    = 1'b0;
                    iorw_n    = 1'b0;
                    ioaddr    = ADDR_DBUF;
                    bus_drive = 1'b1;
                    wdata     = tx_data;
                    tx_ready  = 1'b1;
                end
                RX_RD: begin
                    iocs_n = 1'b0;
                    ioaddr = ADDR_DBUF;
                end
                default: ;
            endcase
        end
    end

    assign databus = bus_drive ? wdata : 8'bzzzz_zzzz;

    // Credits, round-robin pointer, RX holding register and config flag
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_credit <= CW'(0);
            rx_credit <= CW'(0);
            rr_tx     <= 1'b1;
            rx_valid  <= 1'b0;
            rx_data   <= 8'h00;
            cfg_done  <= 1'b0;
        end else begin
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            case (state)
                CFG_H: cfg_done <= 1'b1;
                POLL: begin
                    tx_credit <= databus[7:4];
                    rx_credit <= databus[3:0];
                end
                SERVE: begin
                    if (!pick_tx && !pick_rx) begin
                        tx_credit <= CW'(0);
                        rx_credit <= CW'(0);
                    end
                end
                TX_WR: begin
                    if (tx_credit != CW'(0)) tx_credit <= tx_credit - CW'(1);
                    rr_tx <= 1'b0;
                end
                RX_RD: begin
                    rx_data  <= databus;
                    rx_valid <= 1'b1;
                    if (rx_credit != CW'(0)) rx_credit <= rx_credit - CW'(1);
                    rr_tx <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spart_host_ctrl.sv
// Bench for spart_host_ctrl: a queue-based SPART model on the bus side, a queue-based
// host on the valid/ready side, and per-scenario checks of order, timing and data.
module tb_spart_host_ctrl;

    localparam logic [12:0] BD = 13'd162;
    localparam logic [7:0] EV_P = 8'h50;
    localparam logic [7:0] EV_T = 8'h54;
    localparam logic [7:0] EV_R = 8'h52;

    typedef struct packed {
        logic [7:0]  kind;
        logic [7:0]  d;
        logic [31:0] cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iocs_n, iorw_n, tx_ready, rx_valid, cfg_done;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic       tx_q_full = 1'b0, rx_q_empty = 1'b1;
    logic       tx_valid = 1'b0, rx_ready = 1'b0;
    logic [7:0] tx_data = 8'h00, rx_data;

    // SPART model state
    logic       spart_drv = 1'b0;
    logic [7:0] spart_rd = 8'h00;
    logic [7:0] spart_rx_q[$];
    logic [7:0] spart_got[$];
    int         spart_tx_cnt = 0;
    int         sreg_force = -1;
    bit         drain_en = 1'b0;
    bit         pop_pending = 1'b0;
    // Host model state
    logic [7:0] host_tx_q[$];
    logic [7:0] host_rx_got[$];
    bit         tx_taken = 1'b0;
    int         rx_ready_mode = 0;
    // Logging and accounting
    ev_t        ev_q[$];
    int         cyc = 0;
    int         budget_tx = 0, budget_rx = 0, since_tx = 0, since_rx = 0;
    int         vectors = 0, miscompares = 0;

    spart_host_ctrl dut (
        .clk(clk), .rst(rst), .iocs_n(iocs_n), .iorw_n(iorw_n), .ioaddr(ioaddr),
        .databus(databus), .tx_q_full(tx_q_full), .rx_q_empty(rx_q_empty),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .cfg_done(cfg_done)
    );

    assign databus = spart_drv ? spart_rd : 8'bzzzz_zzzz;

    always #5 clk = ~clk;

    // Host side: present queued TX bytes, retire them after a handshake, drive rx_ready
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tx_taken) begin
                if (host_tx_q.size() > 0) host_tx_q.delete(0);
                tx_taken = 1'b0;
            end
            tx_valid = (host_tx_q.size() > 0);
            tx_data  = (host_tx_q.size() > 0) ? host_tx_q[0] : 8'h00;
            rx_ready = (rx_ready_mode == 2) ? 1'($urandom_range(0, 1)) : (rx_ready_mode == 1);
        end
    end

    // SPART side: observe each access mid-cycle, serve reads, account credits
    always @(negedge clk) begin
        logic [7:0] sreg;
        cyc++;
        if (pop_pending) begin
            if (spart_rx_q.size() > 0) spart_rx_q.delete(0);
            pop_pending = 1'b0;
        end
        if (tx_ready) tx_taken = 1'b1;
        if (rx_valid && rx_ready) host_rx_got.push_back(rx_data);
        if (sreg_force >= 0) sreg = sreg_force[7:0];
        else sreg = {4'(8 - spart_tx_cnt), 4'(spart_rx_q.size())};
        spart_drv = 1'b0;
        if (!iocs_n) begin
            if (iorw_n && ioaddr == 2'b01) begin
                spart_drv = 1'b1;
                spart_rd  = sreg;
                ev_q.push_back('{EV_P, sreg, 32'(cyc)});
                budget_tx = int'(sreg[7:4]);
                budget_rx = int'(sreg[3:0]);
                since_tx  = 0;
                since_rx  = 0;
            end else if (iorw_n && ioaddr == 2'b00) begin
                spart_drv = 1'b1;
                spart_rd  = (spart_rx_q.size() > 0) ? spart_rx_q[0] : 8'h00;
                ev_q.push_back('{EV_R, spart_rd, 32'(cyc)});
                pop_pending = 1'b1;
                since_rx++;
                vectors++;
                if (since_rx > budget_rx) begin
                    miscompares++;
                    $display("FAIL rx_credit: %0d reads since poll, allowed %0d", since_rx, budget_rx);
                end
            end else if (!iorw_n && ioaddr == 2'b00) begin
                ev_q.push_back('{EV_T, databus, 32'(cyc)});
                spart_got.push_back(databus);
                spart_tx_cnt++;
                since_tx++;
                vectors++;
                if (since_tx > budget_tx) begin
                    miscompares++;
                    $display("FAIL tx_credit: %0d writes since poll, allowed %0d", since_tx, budget_tx);
                end
            end
        end else begin
            vectors++;
            if (iorw_n !== 1'b1 || ioaddr !== 2'b00) begin
                miscompares++;
                $display("FAIL bus_idle: iorw_n=%b ioaddr=%b, required 1/00", iorw_n, ioaddr);
            end
        end
        vectors++;
        if (tx_ready !== (!iocs_n && !iorw_n && ioaddr == 2'b00)) begin
            miscompares++;
            $display("FAIL tx_ready_cycle: tx_ready=%b iocs_n=%b iorw_n=%b ioaddr=%b",
                     tx_ready, iocs_n, iorw_n, ioaddr);
        end
        if (drain_en && spart_tx_cnt > 0 && $urandom_range(0, 3) == 0) spart_tx_cnt--;
        tx_q_full  = (spart_tx_cnt >= 8);
        rx_q_empty = (spart_rx_q.size() == 0);
    end

    function automatic int count_kind(logic [7:0] k);
        int n = 0;
        foreach (ev_q[i]) if (ev_q[i].kind == k) n++;
        return n;
    endfunction

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        host_tx_q.delete();
        spart_rx_q.delete();
        sreg_force = -1;
        drain_en = 1'b0;
        rx_ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ev_q.delete();
        spart_got.delete();
        host_rx_got.delete();
        spart_tx_cnt = 0;
        tx_taken = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (iocs_n !== 1'b1 || tx_ready !== 1'b0 || cfg_done !== 1'b0 || rx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: iocs_n=%b tx_ready=%b cfg_done=%b rx_valid=%b, required 1/0/0/0",
                     iocs_n, tx_ready, cfg_done, rx_valid);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (iocs_n !== 1'b0 || iorw_n !== 1'b0 || ioaddr !== 2'b10 || databus !== BD[7:0]) begin
            miscompares++;
            $display("FAIL cfg_dbl: cs=%b rw=%b addr=%b data=%h, required 0/0/10/%h",
                     iocs_n, iorw_n, ioaddr, databus, BD[7:0]);
        end
        @(negedge clk);
        vectors++;
        if (iocs_n !== 1'b0 || iorw_n !== 1'b0 || ioaddr !== 2'b11 || databus !== {3'b000, BD[12:8]}) begin
            miscompares++;
            $display("FAIL cfg_dbh: cs=%b rw=%b addr=%b data=%h, required 0/0/11/%h",
                     iocs_n, iorw_n, ioaddr, databus, {3'b000, BD[12:8]});
        end
        @(negedge clk);
        vectors++;
        if (cfg_done !== 1'b1 || iocs_n !== 1'b1) begin
            miscompares++;
            $display("FAIL cfg_done: cfg_done=%b iocs_n=%b, required 1/1", cfg_done, iocs_n);
        end
    endtask

    task automatic test_tx_single();
        apply_reset();
        host_tx_q.push_back(8'h5A);
        for (int i = 0; i < 60 && count_kind(EV_T) == 0; i++) @(posedge clk);
        repeat (10) @(posedge clk);
        vectors++;
        if (ev_q.size() != 2) begin
            miscompares++;
            $display("FAIL tx_single_count: %0d accesses, required 2", ev_q.size());
        end else begin
            vectors++;
            if (ev_q[0].kind != EV_P || ev_q[0].d != 8'h80 || ev_q[1].kind != EV_T ||
                ev_q[1].d != 8'h5A || ev_q[1].cyc != ev_q[0].cyc + 2) begin
                miscompares++;
                $display("FAIL tx_single_seq: %c/%h@%0d %c/%h@%0d, required P/80 then T/5a two cycles later",
                         ev_q[0].kind, ev_q[0].d, ev_q[0].cyc, ev_q[1].kind, ev_q[1].d, ev_q[1].cyc);
            end
        end
    endtask

    task automatic test_rx_burst();
        logic [7:0] exp[$];
        apply_reset();
        rx_ready_mode = 1;
        for (int i = 0; i < 3; i++) begin
            exp.push_back(8'($urandom));
            spart_rx_q.push_back(exp[i]);
        end
        for (int i = 0; i < 200 && host_rx_got.size() < 3; i++) @(posedge clk);
        repeat (10) @(posedge clk);
        vectors++;
        if (host_rx_got.size() != 3 || count_kind(EV_R) != 3) begin
            miscompares++;
            $display("FAIL rx_burst_count: got %0d bytes, %0d reads, required 3/3",
                     host_rx_got.size(), count_kind(EV_R));
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (host_rx_got[i] !== exp[i]) begin
                    miscompares++;
                    $display("FAIL rx_burst_data[%0d]: %h, required %h", i, host_rx_got[i], exp[i]);
                end
            end
        end
        @(negedge clk);
        vectors++;
        if (rx_valid !== 1'b0 || iocs_n !== 1'b1) begin
            miscompares++;
            $display("FAIL rx_burst_idle: rx_valid=%b iocs_n=%b, required 0/1", rx_valid, iocs_n);
        end
    endtask

    task automatic test_rx_backpressure();
        logic [7:0] exp[$];
        apply_reset();
        rx_ready_mode = 0;
        for (int i = 0; i < 3; i++) begin
            exp.push_back(8'($urandom));
            spart_rx_q.push_back(exp[i]);
        end
        repeat (40) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (count_kind(EV_R) != 1 || count_kind(EV_P) != 1 || rx_valid !== 1'b1 || rx_data !== exp[0]) begin
            miscompares++;
            $display("FAIL rx_hold: reads=%0d polls=%0d rx_valid=%b rx_data=%h, required 1/1/1/%h",
                     count_kind(EV_R), count_kind(EV_P), rx_valid, rx_data, exp[0]);
        end
        rx_ready_mode = 1;
        for (int i = 0; i < 200 && host_rx_got.size() < 3; i++) @(posedge clk);
        vectors++;
        if (host_rx_got.size() != 3) begin
            miscompares++;
            $display("FAIL rx_release: got %0d bytes, required 3", host_rx_got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (host_rx_got[i] !== exp[i]) begin
                    miscompares++;
                    $display("FAIL rx_release_data[%0d]: %h, required %h", i, host_rx_got[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_interleave();
        logic [7:0] txb[$], rxb[$];
        logic [7:0] want_k[6];
        logic [7:0] want_d[6];
        apply_reset();
        sreg_force = 32'h22;
        rx_ready_mode = 1;
        for (int i = 0; i < 4; i++) begin
            txb.push_back(8'($urandom));
            rxb.push_back(8'($urandom));
            spart_rx_q.push_back(rxb[i]);
        end
        foreach (txb[i]) host_tx_q.push_back(txb[i]);
        want_k = '{EV_P, EV_T, EV_R, EV_T, EV_R, EV_P};
        want_d = '{8'h22, txb[0], rxb[0], txb[1], rxb[1], 8'h22};
        for (int i = 0; i < 100 && ev_q.size() < 6; i++) @(posedge clk);
        vectors++;
        if (ev_q.size() < 6) begin
            miscompares++;
            $display("FAIL rr_timeout: %0d accesses, required 6", ev_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                vectors++;
                if (ev_q[i].kind != want_k[i] || ev_q[i].d != want_d[i]) begin
                    miscompares++;
                    $display("FAIL rr_order[%0d]: %c/%h, required %c/%h",
                             i, ev_q[i].kind, ev_q[i].d, want_k[i], want_d[i]);
                end
            end
        end
    endtask

    task automatic test_tx_limited();
        logic [7:0] txb[3];
        apply_reset();
        sreg_force = 32'h10;
        for (int i = 0; i < 3; i++) txb[i] = 8'($urandom);
        foreach (txb[i]) host_tx_q.push_back(txb[i]);
        for (int i = 0; i < 100 && count_kind(EV_T) < 3; i++) @(posedge clk);
        repeat (10) @(posedge clk);
        vectors++;
        if (ev_q.size() != 6) begin
            miscompares++;
            $display("FAIL tx_limited_count: %0d accesses, required 6", ev_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (ev_q[2*i].kind != EV_P || ev_q[2*i+1].kind != EV_T || ev_q[2*i+1].d != txb[i] ||
                    ev_q[2*i+1].cyc != ev_q[2*i].cyc + 2 ||
                    (i > 0 && ev_q[2*i].cyc != ev_q[2*i-1].cyc + 3)) begin
                    miscompares++;
                    $display("FAIL tx_limited[%0d]: %c@%0d %c/%h@%0d, required P then T/%h two cycles later",
                             i, ev_q[2*i].kind, ev_q[2*i].cyc, ev_q[2*i+1].kind,
                             ev_q[2*i+1].d, ev_q[2*i+1].cyc, txb[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_tx[$], exp_rx[$];
        int n_tx = 0, n_rx = 0;
        apply_reset();
        drain_en = 1'b1;
        rx_ready_mode = 2;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #2;
            if (n_tx < 40 && host_tx_q.size() < 4 && $urandom_range(0, 2) == 0) begin
                exp_tx.push_back(8'($urandom));
                host_tx_q.push_back(exp_tx[n_tx]);
                n_tx++;
            end
            if (n_rx < 40 && spart_rx_q.size() < 7 && $urandom_range(0, 2) == 0) begin
                exp_rx.push_back(8'($urandom));
                spart_rx_q.push_back(exp_rx[n_rx]);
                n_rx++;
            end
        end
        for (int i = 0; i < 3000 && (spart_got.size() < n_tx || host_rx_got.size() < n_rx); i++)
            @(posedge clk);
        vectors++;
        if (spart_got.size() != n_tx || host_rx_got.size() != n_rx) begin
            miscompares++;
            $display("FAIL random_count: tx %0d/%0d rx %0d/%0d", spart_got.size(), n_tx,
                     host_rx_got.size(), n_rx);
        end else begin
            for (int i = 0; i < n_tx; i++) begin
                vectors++;
                if (spart_got[i] !== exp_tx[i]) begin
                    miscompares++;
                    $display("FAIL random_tx[%0d]: %h, required %h", i, spart_got[i], exp_tx[i]);
                end
            end
            for (int i = 0; i < n_rx; i++) begin
                vectors++;
                if (host_rx_got[i] !== exp_rx[i]) begin
                    miscompares++;
                    $display("FAIL random_rx[%0d]: %h, required %h", i, host_rx_got[i], exp_rx[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int waited = 0;
        apply_reset();
        host_tx_q.push_back(8'($urandom));
        @(negedge clk);
        while (tx_ready !== 1'b1 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (tx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_wait: tx_ready=%b, required 1 within 60 cycles", tx_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (iocs_n !== 1'b1 || tx_ready !== 1'b0 || cfg_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: iocs_n=%b tx_ready=%b cfg_done=%b, required 1/0/0",
                     iocs_n, tx_ready, cfg_done);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (iocs_n !== 1'b0 || iorw_n !== 1'b0 || ioaddr !== 2'b10 || databus !== BD[7:0]) begin
            miscompares++;
            $display("FAIL reset_mid_cfg: cs=%b rw=%b addr=%b data=%h, required 0/0/10/%h",
                     iocs_n, iorw_n, ioaddr, databus, BD[7:0]);
        end
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_rx_burst();
        test_rx_backpressure();
        test_interleave();
        test_tx_limited();
        test_random();
        test_reset_mid();
        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
